// File: rtl/gcnt_sched.sv
// -----------------------------------------------------------------------------
// gcnt_sched
//   Two-requester scheduler that shares one up/down binary counter and presents
//   its Gray encoding. A round-robin arbiter accepts one command at a time. The
//   block then steps the counter once per clock and pulses `done` tagged with
//   the owning requester.
//
//   Handshake: a command on requester N transfers on a rising clock edge where
//   reqN_valid && reqN_ready. Ready is combinational, high only in IDLE, and
//   high for at most one requester. A requester holds valid and its command
//   stable until the transfer happens.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   reqN_valid/dir/steps command from requester N (dir 0 = up, 1 = down)
//   reqN_ready          command from requester N accepted this cycle
//   bin_out, gray_out   registered binary count and its Gray encoding
//   busy                high while a command is running or completing
//   done, done_id       one-cycle completion pulse and owning requester
//   state_dbg           current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module gcnt_sched #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_dir,
    input  logic [STEP_W-1:0] req0_steps,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_dir,
    input  logic [STEP_W-1:0] req1_steps,
    output logic              req1_ready,
    output logic [WIDTH-1:0]  bin_out,
    output logic [WIDTH-1:0]  gray_out,
    output logic              busy,
    output logic              done,
    output logic              done_id,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]  CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [STEP_W-1:0] remain;
    logic              dir_q;
    logic              owner;
    logic              last;

    logic              grant;
    logic              fire;
    logic              sel_dir;
    logic [STEP_W-1:0] sel_steps;

    // On a tie the requester that was not granted last wins. Otherwise the
    // valid requester wins. With no request, grant points at requester 0.
    always_comb begin
        grant     = 1'b0;
        fire      = 1'b0;
        sel_dir   = 1'b0;
        sel_steps = '0;
        if (req0_valid && req1_valid) begin
            grant = ~last;
        end else begin
            grant = req1_valid;
        end
        sel_dir   = grant ? req1_dir   : req0_dir;
        sel_steps = grant ? req1_steps : req0_steps;
        fire      = (state == IDLE) && (grant ? req1_valid : req0_valid);
    end

    assign req0_ready = (state == IDLE) && !grant;
    assign req1_ready = (state == IDLE) &&  grant;
    assign gray_out   = bin_out ^ (bin_out >> 1);
    assign done_id    = owner;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bin_out <= '0;
            remain  <= '0;
            dir_q   <= 1'b0;
            owner   <= 1'b0;
            last    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        owner  <= grant;
                        last   <= grant;
                        dir_q  <= sel_dir;
                        remain <= sel_steps;
                        busy   <= 1'b1;
                        // A zero-step command completes without touching the count.
                        if (sel_steps == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    bin_out <= dir_q ? (bin_out - CNT_ONE) : (bin_out + CNT_ONE);
                    remain  <= remain - STEP_ONE;
                    if (remain == STEP_ONE) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcnt_sched.sv
module tb_gcnt_sched;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_dir, req0_ready;
    logic [3:0] req0_steps;
    logic       req1_valid, req1_dir, req1_ready;
    logic [3:0] req1_steps;
    logic [3:0] bin_out, gray_out;
    logic       busy, done, done_id;
    logic [1:0] state_dbg;

    int         n_checks;
    int         n_fail;
    logic [3:0] m_bin;
    logic [3:0] exp_q[$];
    logic       mon_en;

    gcnt_sched #(.WIDTH(4), .STEP_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_dir   (req0_dir),
        .req0_steps (req0_steps),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_dir   (req1_dir),
        .req1_steps (req1_steps),
        .req1_ready (req1_ready),
        .bin_out    (bin_out),
        .gray_out   (gray_out),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_bin",   bin_out,   4'd0);
        check("rst_gray",  gray_out,  4'd0);
        check("rst_busy",  busy,      1'b0);
        check("rst_done",  done,      1'b0);
        check("rst_id",    done_id,   1'b0);
        check("rst_state", state_dbg, 2'd0);
        m_bin = 4'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: ready must never be high for both requesters.
    always @(negedge clk) begin
        if (mon_en) check("ready_excl", {31'd0, req0_ready & req1_ready}, 32'd0);
    end

    // ---------------- driver tasks ----------------
    // Present a command on requester id, wait (bounded) for ready, and let it
    // transfer on the next rising edge. Returns just after that edge.
    task automatic do_accept(input logic id, input logic dir, input logic [3:0] steps);
        int wait_cnt;
        @(negedge clk);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_dir = dir; req0_steps = steps;
        end else begin
            req1_valid = 1'b1; req1_dir = dir; req1_steps = steps;
        end
        #1;
        wait_cnt = 0;
        while (((id == 1'b0) ? req0_ready : req1_ready) !== 1'b1 && wait_cnt < 10) begin
            @(negedge clk);
            #1;
            wait_cnt++;
        end
        check("accept_ready", (id == 1'b0) ? req0_ready : req1_ready, 1'b1);
        @(posedge clk);
        #1;
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    // Called just after the accept edge: follows the command to its done pulse.
    task automatic follow(input logic id, input logic dir, input logic [3:0] steps);
        logic [3:0] e;
        e = m_bin;
        exp_q.push_back(e);
        for (int i = 1; i <= int'(steps); i++) begin
            e = dir ? e - 4'd1 : e + 4'd1;
            exp_q.push_back(e);
        end
        for (int i = 0; i <= int'(steps); i++) begin
            @(negedge clk);
            m_bin = exp_q.pop_front();
            check("run_bin",  bin_out,  m_bin);
            check("run_gray", gray_out, to_gray(m_bin));
            check("run_busy", busy,     1'b1);
            check("run_done", done,     (i == int'(steps)) ? 1'b1 : 1'b0);
            if (i == int'(steps)) check("done_id", done_id, id);
        end
    endtask

    task automatic check_idle();
        @(negedge clk);
        check("idle_done", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_bin",  bin_out, m_bin);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0; n_fail = 0; mon_en = 1'b0;
        rst = 1'b1; m_bin = 4'd0;
        req0_valid = 1'b0; req0_dir = 1'b0; req0_steps = 4'd0;
        req1_valid = 1'b0; req1_dir = 1'b0; req1_steps = 4'd0;
        do_reset();
        mon_en = 1'b1;

        // Up count: 5 steps from 0, gray 0001 0011 0010 0110 0111.
        do_accept(1'b0, 1'b0, 4'd5);
        follow(1'b0, 1'b0, 4'd5);
        check("up_final_bin",  bin_out,  4'd5);
        check("up_final_gray", gray_out, 4'b0111);
        check_idle();

        // Down with wrap from 0: 15, 14, 13; gray of 13 = 1011.
        do_reset();
        do_accept(1'b1, 1'b1, 4'd3);
        follow(1'b1, 1'b1, 4'd3);
        check("dn_final_bin",  bin_out,  4'd13);
        check("dn_final_gray", gray_out, 4'b1011);
        check_idle();

        // Simultaneous requests after reset: req0 first, then req1.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_dir = 1'b0; req0_steps = 4'd2;
        req1_valid = 1'b1; req1_dir = 1'b0; req1_steps = 4'd2;
        #1;
        check("tie_r0_ready", req0_ready, 1'b1);
        check("tie_r1_ready", req1_ready, 1'b0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        follow(1'b0, 1'b0, 4'd2);
        check("tie_first_bin", bin_out, 4'd2);
        check("tie_done_r1_ready", req1_ready, 1'b0);
        @(negedge clk);
        check("tie_r1_ready2", req1_ready, 1'b1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        follow(1'b1, 1'b0, 4'd2);
        check("tie_second_bin", bin_out, 4'd4);
        check_idle();

        // Zero steps at bin_out = 4.
        do_accept(1'b0, 1'b0, 4'd0);
        follow(1'b0, 1'b0, 4'd0);
        check("zero_bin", bin_out, 4'd4);
        check_idle();

        // Reset after 2 of 8 steps: immediate reset values, no done pulse.
        do_accept(1'b1, 1'b0, 4'd8);
        @(negedge clk);
        check("mid_bin0", bin_out, 4'd4);
        @(negedge clk);
        check("mid_bin1", bin_out, 4'd5);
        @(negedge clk);
        check("mid_bin2", bin_out, 4'd6);
        check("mid_busy", busy, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("ares_bin",   bin_out,   4'd0);
        check("ares_gray",  gray_out,  4'd0);
        check("ares_busy",  busy,      1'b0);
        check("ares_done",  done,      1'b0);
        check("ares_state", state_dbg, 2'd0);
        m_bin = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_done", done, 1'b0);
            check("post_rst_bin",  bin_out, 4'd0);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcnt_sched.md
# gcnt_sched

Two-requester scheduler that shares one 4-bit up/down Gray-code counter resource. Each requester submits a command (direction and step count) over a valid/ready handshake. A round-robin arbiter grants one command at a time. The block then steps the shared binary counter once per cycle and presents its Gray encoding, and finally pulses `done` tagged with the owning requester's ID.

## Interface
- `WIDTH`, 4: counter width in bits; `gray_out`/`bin_out` width.
- `STEP_W`, 4: width of the step-count field; maximum steps per command is 2^STEP_W-1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a command.
- `req0_dir`  in  1  0 = count up, 1 = count down.
- `req0_steps`  in  STEP_W  number of single steps to apply.
- `req0_ready`  out  1  requester 0 command accepted this cycle when high with `req0_valid`.
- `req1_valid`, `req1_dir`, `req1_steps`, `req1_ready`: same as the requester 0 ports, for requester 1.
- `bin_out`  out  WIDTH  current binary counter value.
- `gray_out`  out  WIDTH  `bin_out ^ (bin_out >> 1)`, combinational from the registered count.
- `busy`  out  1  high in RUN and DONE states.
- `done`  out  1  one-cycle completion pulse.
- `done_id`  out  1  ID of the requester whose command completed; valid while `done` is high.

## Operation
- States:
  - IDLE: accepting commands.
  - RUN: stepping the counter.
  - DONE: emitting the completion pulse.
- IDLE arbitration:
  - Grant uses the `last` pointer. When both requests are valid, the requester not granted last wins.
  - When only one request is valid, that requester wins.
  - `reqN_ready` = (state == IDLE) && grant == N. Ready is combinational and never high for both requesters.
  - `ready` is low in RUN and DONE.
- Accept (valid && ready at a clock edge):
  - Latch `dir`, `steps` into `remain`, and `owner`.
  - Set `last` = owner.
  - If steps != 0, go to RUN; if steps == 0, go directly to DONE with the counter unchanged.
- RUN:
  - Each clock, `bin_out` += 1 (dir 0) or -= 1 (dir 1), modulo 2^WIDTH, and `remain` -= 1.
  - When `remain` == 1 at the edge, apply the final step and go to DONE.
- DONE:
  - `done` = 1 and `done_id` = owner for exactly one cycle, then return to IDLE.
- Wrap-around: 4'b1111 + 1 yields 4'b0000, and 4'b0000 - 1 yields 4'b1111. There is no saturation and no error flag.
- The counter value persists across commands. It is reset only by `rst`.
- Inputs on a requester's ports are ignored while its `ready` is low. The requester must hold `valid` and its command until accepted.

## Timing
- Reset (asynchronous assert, `rst` = 0), all outputs and state:
  - `bin_out` = 0, `gray_out` = 0.
  - state = IDLE, `busy` = 0, `done` = 0, `done_id` = 0.
  - `remain` = 0, `last` = 1, so requester 0 wins the first tie.
- Reset asserted mid-RUN or mid-DONE aborts the command immediately with no `done` pulse. The counter returns to 0.
- Command with N ≥ 1 steps, accepted at edge E:
  - `bin_out` changes at edges E+1 … E+N.
  - `done` is high during the cycle following edge E+N and falls at E+N+1.
  - IDLE resumes at E+N+1, so the next accept is possible at E+N+1.
- Command with N = 0, accepted at edge E: `done` is high for the cycle after E, and IDLE resumes at E+1.
- A requester that keeps `valid` high in the DONE cycle is considered in the following IDLE cycle. A pending other requester has priority over it per round-robin.
- `gray_out` updates in the same cycle as `bin_out`; there is no extra latency.

## Test plan
- **Reset:**
  - Stimulus: `rst` low, then release.
  - Required: `bin_out` = 0, `gray_out` = 0, `busy` = 0, `done` = 0; `req0_ready` = 1 on the first cycle `req0_valid` is high.
- **Up count:**
  - Stimulus: from 0, req0 up, 5 steps.
  - Required: `gray_out` sequence 0001, 0011, 0010, 0110, 0111 on consecutive cycles; `done` = 1 with `done_id` = 0 one cycle after `bin_out` = 5; `busy` is high for 6 cycles.
- **Down with wrap:**
  - Stimulus: from 0, req1 down, 3 steps.
  - Required: `bin_out` 15, 14, 13; final `gray_out` = 1011; `done_id` = 1.
- **Simultaneous requests after reset:**
  - Stimulus: both valid, each up 2 steps.
  - Required: req0 granted first (`bin_out` 1, 2, then `done_id` = 0); req1 is then accepted in the next IDLE cycle (`bin_out` 3, 4, then `done_id` = 1). `ready` is never high for both requesters.
- **Zero steps:**
  - Stimulus: req0 with steps = 0 at `bin_out` = 4.
  - Required: `done` is high the cycle after accept, and `bin_out` stays 4.
- **Reset mid-operation:**
  - Stimulus: assert `rst` while in RUN after 2 of 8 steps.
  - Required: outputs go to reset values asynchronously, with no `done` pulse.
